// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial AND/OR/XOR/ADD sequencer: one result bit per clock, LSB first.
// Latency WIDTH+1 edges from start accept to done; start ignored while busy/done.
module bitserial_alu_ctrl #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, work_q, work_d, result_q;
    logic [1:0]         op_q;
    logic               c_q, c_d;
    logic               cout_q, zero_q;
    logic               bit_d;
    logic               last_bit;

    assign last_bit = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Any illegal encoding falls back to IDLE through the default arm.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // The 1-bit cell: operand LSBs plus the carry flop.
    always_comb begin
        bit_d = 1'b0;
        c_d   = 1'b0;
        case (op_q)
            OP_AND: bit_d = a_q[0] & b_q[0];
            OP_OR:  bit_d = a_q[0] | b_q[0];
            OP_XOR: bit_d = a_q[0] ^ b_q[0];
            OP_ADD: begin
                bit_d = a_q[0] ^ b_q[0] ^ c_q;
                c_d   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
            end
            default: ;
        endcase
        work_d = {bit_d, work_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        op_q   <= op;
                        cnt_q  <= '0;
                        c_q    <= 1'b0;
                        work_q <= '0;
                    end
                end
                S_RUN: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    c_q    <= c_d;
                    work_q <= work_d;
                    cnt_q  <= last_bit ? '0 : cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        result_q <= work_d;
                        cout_q   <= c_d;
                        zero_q   <= (work_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Directed bench for bitserial_alu_ctrl at WIDTH=32, 8 and 2.
module tb_bitserial_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [1:0]  op;
    logic [31:0] A, B;

    logic        busy32, done32, cout32, zero32;
    logic [31:0] res32;
    logic        busy8, done8, cout8, zero8;
    logic [7:0]  res8;
    logic        busy2, done2, cout2, zero2;
    logic [1:0]  res2;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res [3];

    always #5 clk = ~clk;

    bitserial_alu_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .A(A), .B(B),
        .busy(busy32), .done(done32), .result(res32), .carry_out(cout32), .zero(zero32));
    bitserial_alu_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .A(A[7:0]), .B(B[7:0]),
        .busy(busy8), .done(done8), .result(res8), .carry_out(cout8), .zero(zero8));
    bitserial_alu_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .A(A[1:0]), .B(B[1:0]),
        .busy(busy2), .done(done2), .result(res2), .carry_out(cout2), .zero(zero2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_done(int s);
        return (s == 0) ? done32 : (s == 1) ? done8 : done2;
    endfunction
    function automatic logic g_busy(int s);
        return (s == 0) ? busy32 : (s == 1) ? busy8 : busy2;
    endfunction
    function automatic logic [31:0] g_res(int s);
        return (s == 0) ? res32 : (s == 1) ? {24'd0, res8} : {30'd0, res2};
    endfunction
    function automatic logic g_cout(int s);
        return (s == 0) ? cout32 : (s == 1) ? cout8 : cout2;
    endfunction
    function automatic logic g_zero(int s);
        return (s == 0) ? zero32 : (s == 1) ? zero8 : zero2;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle.
    task automatic run(input int s, input int w, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ec, input logic ez,
                       input string tag);
        int lat = 0;
        int busy_cnt = 0;
        bit hold_ok = 1'b1;
        start_v[s] = 1'b1;
        op = o; A = a; B = b;
        @(negedge clk);
        start_v[s] = 1'b0;
        op = ~o; A = ~a; B = ~b;
        while (!g_done(s) && lat < 200) begin
            if (g_busy(s)) busy_cnt++;
            if (g_res(s) !== last_res[s]) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(w));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(w));
        chk({tag, " result_held"}, 64'(hold_ok), 64'd1);
        chk({tag, " result"}, 64'(g_res(s)), 64'(er));
        chk({tag, " carry_out"}, 64'(g_cout(s)), 64'(ec));
        chk({tag, " zero"}, 64'(g_zero(s)), 64'(ez));
        chk({tag, " busy_in_done"}, 64'(g_busy(s)), 64'd0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(g_done(s)), 64'd0);
        last_res[s] = er;
    endtask

    initial begin
        logic [32:0] pend [3];
        logic [31:0] held;
        logic [31:0] ra, rb;
        int          seen;

        reset = 1'b1;
        start_v = 3'b000;
        op = 2'b00; A = '0; B = '0;
        for (int i = 0; i < 3; i++) last_res[i] = '0;
        #1;
        chk("rst busy", 64'(busy32), 64'd0);
        chk("rst done", 64'(done32), 64'd0);
        chk("rst result", 64'(res32), 64'd0);
        chk("rst carry", 64'(cout32), 64'd0);
        chk("rst zero", 64'(zero32), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(0, 32, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, "xor32");
        run(0, 32, 2'b00, 32'hAAAA5555, 32'h0F0F0F0F, 32'h0A0A0505, 1'b0, 1'b0, "and32");
        run(0, 32, 2'b01, 32'hAAAA5555, 32'h0F0F0F0F, 32'hAFAF5F5F, 1'b0, 1'b0, "or32");
        run(0, 32, 2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "addwrap32");
        run(0, 32, 2'b11, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, "add32");

        // Abort an ADD mid-run with an asynchronous reset.
        start_v[0] = 1'b1; op = 2'b11; A = 32'd5; B = 32'd7;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort busy_before", 64'(busy32), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy32), 64'd0);
        chk("abort result", 64'(res32), 64'd0);
        chk("abort zero", 64'(zero32), 64'd1);
        chk("abort done", 64'(done32), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_res[0] = '0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen++;
        end
        chk("abort no_done", 64'(seen), 64'd0);
        run(0, 32, 2'b11, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add5p7");

        // start held high, operands changing every cycle: accepts every WIDTH+2 edges.
        held = last_res[0];
        start_v[0] = 1'b1;
        op = 2'b11;
        for (int c = 0; c < 3 * 34; c++) begin
            if (c > 0) begin
                if (((c - 1) % 34) == 32) begin
                    chk("b2b done", 64'(done32), 64'd1);
                    chk("b2b result", 64'(res32), 64'(pend[(c - 1) / 34][31:0]));
                    chk("b2b carry", 64'(cout32), 64'(pend[(c - 1) / 34][32]));
                    held = pend[(c - 1) / 34][31:0];
                end else begin
                    chk("b2b no_done", 64'(done32), 64'd0);
                    chk("b2b held", 64'(res32), 64'(held));
                end
            end
            ra = $urandom;
            rb = $urandom;
            if ((c % 34) == 0) pend[c / 34] = {1'b0, ra} + {1'b0, rb};
            A = ra;
            B = rb;
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        last_res[0] = held;
        chk("b2b idle", 64'(busy32), 64'd0);

        run(1, 8, 2'b11, 32'h000000FF, 32'h00000001, 32'h00, 1'b1, 1'b1, "add8");
        run(2, 2, 2'b10, 32'h00000002, 32'h00000003, 32'h1, 1'b0, 1'b0, "xor2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
